mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 1000: number of 32-bit words in the downstream word RAM; word indices >= MEM_WORDS are out of range.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  CPU memory request; sampled only when ready=1.
REQ-005 ready  output  1  high when a request can be accepted.
REQ-006 we  input  1  1=store, 0=load.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 usgn  input  1  loads only: 1=zero-extend, 0=sign-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-justified.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load result, valid while done=1.
REQ-013 err  output  1  valid with done: access rejected.
REQ-014 ram_address  output  32  RAM word index; equals addr[31:2] zero-extended.
REQ-015 ram_writedata  output  32  full word to write.
REQ-016 ram_load  output  1  RAM write enable.
REQ-017 ram_out  input  32  RAM combinational read data.

Function
REQ-018 Byte order SHALL be big-endian: byte offset 0 = bits [31:24], halfword offset 0 = bits [31:16].
REQ-019 FSM states SHALL be IDLE, RD, WR, RESP; ready=1 only in IDLE.
REQ-020 On req=1 in IDLE, we, size, usgn, addr and wdata SHALL be captured; later input changes SHALL be ignored until the next IDLE.
REQ-021 Error check at acceptance: size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS SHALL go IDLE->RESP with err=1, rdata=0, and no RAM write.
REQ-022 Loads SHALL go IDLE->RD->RESP; RD captures ram_out into a word register; done high two cycles after the accepting edge.
REQ-023 Word stores SHALL go IDLE->WR->RESP; ram_writedata=wdata.
REQ-024 Byte and halfword stores SHALL go IDLE->RD->WR->RESP; WR writes the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; done high three cycles after accept.
REQ-025 Load extraction SHALL select the addressed lane and sign- or zero-extend it per usgn; word loads ignore usgn.
REQ-026 ram_load SHALL be high only for the single WR cycle and low in every other state.
REQ-027 ram_address SHALL be updated only at acceptance and held constant through RD, WR and RESP, and until the next acceptance.
REQ-028 done SHALL be high exactly in RESP; err and rdata SHALL be 0 when done=0.
REQ-029 RESP SHALL return to IDLE unconditionally; a req present during RESP SHALL NOT be accepted until the following IDLE cycle.
REQ-030 Back-to-back requests SHALL be accepted every (latency+1) cycles with no lost or merged accesses.

Reset
REQ-031 On reset assertion, the block SHALL immediately enter IDLE and force ram_load=0, done=0, err=0, rdata=0, ram_address=0, ram_writedata=0.
REQ-032 Reset mid-transaction SHALL abandon it; no RAM write SHALL occur for an access interrupted before its WR edge.
REQ-033 The first request SHALL be accepted in the first cycle after reset deassertion.

Structure
REQ-034 Package mem_access_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encoding.
REQ-035 Lane select, extend and merge logic SHALL be a combinational sub-module mem_lane_merge, shared by the load and store paths.

Verification
REQ-036 Write 0x11223344 with a SW to addr 0x10, then LW from 0x10 -> RAM word 4 = 0x11223344, rdata=0x11223344, err=0, done two cycles after accept.
REQ-037 With word 4 = 0x11223344: LB from 0x12 -> 0x00000033; LH from 0x10 -> 0x00001122; word 4 = 0x80FF0000, LB from 0x10 -> 0xFFFFFF80, LBU -> 0x00000080.
REQ-038 With word 4 = 0xAABBCCDD: SB 0x5A to 0x13 -> word 4 = 0xAABBCC5A; SH 0x1234 to 0x10 -> 0x1234CC5A; ram_load high exactly one cycle each.
REQ-039 LW from 0x11, SH to 0x03, size=11, and SW to 4*MEM_WORDS -> each gives err=1, rdata=0, done one cycle after accept, ram_load never high.
REQ-040 Assert reset during the RD cycle of an SB -> ram_load stays 0, RAM word unchanged, ready=1 after deassertion, and the next LW completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller.
//   - size encodings used on the CPU-side size input
//   - FSM state encoding; the state is also exported for debug
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic shared by the load and store paths.
// Big-endian: byte offset 0 is word[31:24], halfword offset 0 is word[31:16].
// Ports:
//   word      - full RAM word (captured read data)
//   wdata     - right-justified store data
//   size      - access size (SZ_*)
//   offset    - byte offset addr[1:0]
//   usgn      - 1 = zero-extend loads, 0 = sign-extend
//   load_data - selected and extended lane (word loads pass through)
//   merged    - word with the addressed lane replaced by wdata
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        usgn,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd1:    byte_lane = word[23:16];
      2'd2:    byte_lane = word[15:8];
      2'd3:    byte_lane = word[7:0];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];

    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~usgn & byte_lane[7]}}, byte_lane};
        merged    = word;
        case (offset)
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          2'd3:    merged[7:0]   = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{~usgn & half_lane[15]}}, half_lane};
        merged    = word;
        if (offset[1]) merged[15:0] = wdata[15:0];
        else           merged[31:16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-word-RAM access controller: byte/halfword/word loads and stores
// on a 32-bit word RAM with a combinational read port.
// Handshake: a request is taken on a rising edge where req=1 and ready=1;
// ready is high only in IDLE. Every accepted request produces exactly one
// done pulse (with err/rdata) and no further request is taken until the
// cycle after that pulse.
// Ports:
//   clock, reset                    - clock, async active-high reset
//   req/ready                       - request handshake
//   we, size, usgn, addr, wdata     - request fields, captured at acceptance
//   done, rdata, err                - one-cycle response
//   ram_address, ram_writedata,
//   ram_load, ram_out               - word RAM port
//   dbg_state                       - current FSM state
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        usgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writedata,
  output logic        ram_load,
  input  logic [31:0] ram_out,
  output logic [1:0]  dbg_state
);

  mem_state_e  state, state_n;
  logic        we_q, usgn_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, word_q;
  logic        bad_req;
  logic [31:0] load_data, merged;

  // Rejection is decided from the live inputs at the accepting edge.
  always_comb begin
    bad_req = 1'b0;
    if (size == SZ_RSVD)                         bad_req = 1'b1;
    if ((size == SZ_HALF) && addr[0])            bad_req = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad_req = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS))   bad_req = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_req)              state_n = RESP;
          else if (!we)             state_n = RD;
          else if (size == SZ_WORD) state_n = WR;
          else                      state_n = RD;  // read-modify-write
        end
      end
      RD:      state_n = we_q ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      usgn_q      <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      word_q      <= 32'h0;
      ram_address <= 32'h0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && req) begin
        we_q        <= we;
        usgn_q      <= usgn;
        err_q       <= bad_req;
        size_q      <= size;
        off_q       <= addr[1:0];
        wdata_q     <= wdata;
        ram_address <= {2'b00, addr[31:2]};
      end
      if (state == RD) word_q <= ram_out;
    end
  end

  // For word stores the merge returns wdata unchanged, so one path serves all.
  mem_lane_merge u_lane (
    .word      (word_q),
    .wdata     (wdata_q),
    .size      (size_q),
    .offset    (off_q),
    .usgn      (usgn_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign ready         = (state == IDLE);
  assign ram_load      = (state == WR);
  assign done          = (state == RESP);
  assign err           = done & err_q;
  assign rdata         = (done && !err_q && !we_q) ? load_data : 32'h0;
  assign ram_writedata = ram_load ? merged : 32'h0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int MW = 64;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, usgn = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ready, done, err, ram_load;
  logic [31:0] rdata, ram_address, ram_writedata, ram_out;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  mem_access_ctrl #(.MEM_WORDS(MW)) dut (
    .clock(clock), .reset(reset), .req(req), .ready(ready), .we(we),
    .size(size), .usgn(usgn), .addr(addr), .wdata(wdata), .done(done),
    .rdata(rdata), .err(err), .ram_address(ram_address),
    .ram_writedata(ram_writedata), .ram_load(ram_load), .ram_out(ram_out),
    .dbg_state(dbg_state)
  );

  // Word RAM driven by the DUT.
  logic [31:0] mem [MW] = '{default: 32'h0};
  assign ram_out = (ram_address < 32'(MW)) ? mem[ram_address[5:0]] : 32'h0;
  always @(posedge clock)
    if (ram_load && (ram_address < 32'(MW))) mem[ram_address[5:0]] <= ram_writedata;

  // ---------------- scoreboard ----------------
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          done_cyc;
    int          wr_cyc;
    logic        is_wr;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [5:0]  widx;
    logic [31:0] wword;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] ref_mem [MW] = '{default: 32'h0};
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] model_last_rdata = 32'h0;
  logic        model_last_err = 1'b0;
  int          cyc = 0;
  int          load_cnt = 0;

  // Reference behaviour of one access accepted at the edge after negedge k.
  function automatic rec_t model_access(input int k, input logic w, input logic [1:0] sz,
                                        input logic u, input logic [31:0] a, input logic [31:0] wd);
    rec_t        r;
    logic [31:0] wordv, v, mask;
    int          o, sh, lat;
    o = int'(a[1:0]);
    r.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && o != 0) ||
            ({2'b00, a[31:2]} >= 32'(MW));
    r.widx   = a[7:2];
    r.is_wr  = 1'b0;
    r.rdata  = 32'h0;
    r.wword  = 32'h0;
    r.chk_rd = 1'b1;
    wordv    = r.err ? 32'h0 : ref_mem[a[7:2]];
    if (r.err) lat = 1;
    else if (!w) begin
      lat = 2;
      if (sz == 2'b00) begin
        v = (wordv >> (8 * (3 - o))) & 32'hff;
        if (!u && v[7]) v = v | 32'hffffff00;
      end else if (sz == 2'b01) begin
        v = (wordv >> ((o >= 2) ? 0 : 16)) & 32'hffff;
        if (!u && v[15]) v = v | 32'hffff0000;
      end else v = wordv;
      r.rdata = v;
    end else begin
      r.is_wr  = 1'b1;
      r.chk_rd = 1'b0;
      if (sz == 2'b10) begin
        lat = 2;
        r.wword = wd;
      end else begin
        lat = 3;
        sh = (sz == 2'b00) ? 8 * (3 - o) : ((o >= 2) ? 0 : 16);
        mask = ((sz == 2'b00) ? 32'hff : 32'hffff) << sh;
        r.wword = (wordv & ~mask) | ((wd << sh) & mask);
      end
    end
    r.done_cyc = k + lat;
    r.wr_cyc   = k + lat - 1;
    return r;
  endfunction

  // Compare process: checks every DUT output on every falling edge.
  always @(negedge clock) begin
    logic idle_now, exp_done, exp_wr;
    cyc++;
    if (reset) begin
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_ram_load", ram_load, 0);
      check("rst_ram_address", ram_address, 0);
      check("rst_ram_writedata", ram_writedata, 0);
      exp_q.delete();
      exp_addr = 32'h0;
    end else begin
      idle_now = (exp_q.size() == 0);
      exp_done = !idle_now && (exp_q[0].done_cyc == cyc);
      exp_wr   = !idle_now && exp_q[0].is_wr && (exp_q[0].wr_cyc == cyc);
      check("ready", ready, idle_now);
      check("done", done, exp_done);
      check("err", err, exp_done ? exp_q[0].err : 1'b0);
      if (!exp_done || exp_q[0].chk_rd)
        check("rdata", rdata, exp_done ? exp_q[0].rdata : 32'h0);
      check("ram_load", ram_load, exp_wr);
      if (ram_load) load_cnt++;
      if (exp_wr) begin
        check("ram_writedata", ram_writedata, exp_q[0].wword);
        ref_mem[exp_q[0].widx] = exp_q[0].wword;
      end
      check("ram_address", ram_address, exp_addr);
      if (exp_done) begin
        model_last_rdata = exp_q[0].rdata;
        model_last_err   = exp_q[0].err;
        void'(exp_q.pop_front());
      end
      if (idle_now && req) begin
        exp_q.push_back(model_access(cyc, we, size, usgn, addr, wdata));
        exp_addr = {2'b00, addr[31:2]};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    we    = 1'($urandom);
    size  = 2'($urandom);
    usgn  = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic access(input string name, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_loads);
    int n, l0;
    logic [31:0] got_rd;
    logic        got_err;
    n = 0;
    while (!ready && n < 20) begin @(posedge clock); #1; n++; end
    check({name, "_ready"}, ready, 1);
    l0 = load_cnt;
    we = w; size = sz; usgn = u; addr = a; wdata = wd; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    scramble();  // captured fields must not follow these
    n = 1;
    while (!done && n < 8) begin @(posedge clock); #1; n++; end
    got_rd  = rdata;
    got_err = err;
    check({name, "_done_latency"}, n, exp_lat);
    check({name, "_err"}, got_err, exp_err);
    if (!w || exp_err) check({name, "_rdata"}, got_rd, exp_rd);
    @(negedge clock); #1;
    if (!w || exp_err) check({name, "_model_rdata"}, model_last_rdata, exp_rd);
    check({name, "_model_err"}, model_last_err, exp_err);
    check({name, "_ram_load_cycles"}, load_cnt - l0, exp_loads);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Store then load a full word.
    access("sw_10", 1, 2'b10, 0, 32'h10, 32'h11223344, 2, 0, 32'h0, 1);
    check("mem4_after_sw", mem[4], 32'h11223344);
    access("lw_10", 0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 32'h11223344, 0);
    access("lb_12", 0, 2'b00, 0, 32'h12, 32'h0, 2, 0, 32'h00000033, 0);
    access("lh_10", 0, 2'b01, 0, 32'h10, 32'h0, 2, 0, 32'h00001122, 0);
    access("lhu_12", 0, 2'b01, 1, 32'h12, 32'h0, 2, 0, 32'h00003344, 0);

    // Sign/zero extension.
    access("sw_80ff", 1, 2'b10, 0, 32'h10, 32'h80FF0000, 2, 0, 32'h0, 1);
    access("lb_10", 0, 2'b00, 0, 32'h10, 32'h0, 2, 0, 32'hFFFFFF80, 0);
    access("lbu_10", 0, 2'b00, 1, 32'h10, 32'h0, 2, 0, 32'h00000080, 0);
    access("lh_10s", 0, 2'b01, 0, 32'h10, 32'h0, 2, 0, 32'hFFFF80FF, 0);
    access("lb_11", 0, 2'b00, 0, 32'h11, 32'h0, 2, 0, 32'hFFFFFFFF, 0);

    // Read-modify-write stores; upper wdata bits must be ignored.
    access("sw_aabb", 1, 2'b10, 0, 32'h10, 32'hAABBCCDD, 2, 0, 32'h0, 1);
    access("sb_13", 1, 2'b00, 0, 32'h13, 32'hFFFFFF5A, 3, 0, 32'h0, 1);
    check("mem4_after_sb", mem[4], 32'hAABBCC5A);
    access("sh_10", 1, 2'b01, 0, 32'h10, 32'hFFFF1234, 3, 0, 32'h0, 1);
    check("mem4_after_sh", mem[4], 32'h1234CC5A);

    // Rejected accesses.
    access("lw_11_err", 0, 2'b10, 0, 32'h11, 32'h0, 1, 1, 32'h0, 0);
    access("sh_03_err", 1, 2'b01, 0, 32'h03, 32'hBEEF, 1, 1, 32'h0, 0);
    access("sz11_err", 0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h0, 0);
    access("sw_oor_err", 1, 2'b10, 0, 32'(4 * MW), 32'hDEADBEEF, 1, 1, 32'h0, 0);
    check("mem4_after_err", mem[4], 32'h1234CC5A);
    check("mem0_after_err", mem[0], 32'h0);

    // Reset during the RD cycle of a byte store.
    while (!ready) begin @(posedge clock); #1; end
    we = 1; size = 2'b00; usgn = 0; addr = 32'h10; wdata = 32'h77; req = 1'b1;
    @(posedge clock); #1;   // accepted, now in RD
    req = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid_ready", ready, 1);
    check("rst_mid_mem4", mem[4], 32'h1234CC5A);
    access("lw_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 2, 0, 32'h1234CC5A, 0);

    // Randomized back-to-back traffic, req often held high through RESP.
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      usgn  = 1'($urandom);
      addr  = {22'h0, 8'($urandom_range(0, MW + 1)), 2'($urandom)};
      wdata = $urandom;
      @(posedge clock); #1;
    end
    req = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock); #1;

    for (int i = 0; i < MW; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
